muldiv_seq: RTL

Parametrised iterative multiply/divide unit for the 6309-class datapath, the multi-cycle successor to the fixed 8x8 pipelined multiplier. It performs WIDTH x WIDTH unsigned/signed multiply and 2·WIDTH / WIDTH unsigned/signed divide by shift-add and restoring shift-subtract, one bit per cycle. It sits beside the ALU; the sequencer issues an operation with a start/ready handshake and stalls until done.

---
 rtl/muldiv_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Iterative WIDTH x WIDTH multiply / 2W-by-W divide unit, one bit per cycle.
// Signed ops run on magnitudes; signs and range checks are applied in FIX.
module muldiv_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 start_in,
    input  logic                 abort_in,
    input  logic [1:0]           op_in,
    input  logic [2*WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 ready_out,
    output logic                 busy_out,
    output logic                 done_out,
    output logic [2*WIDTH-1:0]   q_out,
    output logic [3:0]           ccr_out,
    output logic                 div_zero_out
);

    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PREP = 2'd1;
    localparam logic [1:0] ITER = 2'd2;
    localparam logic [1:0] FIX  = 2'd3;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]        state;
    logic [1:0]        op_r;
    logic [W2-1:0]     a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;
    logic [WIDTH-1:0]  opnd;
    logic [CW-1:0]     cnt;
    logic              res_neg;
    logic              dvd_neg;
    logic              exc_dz;
    logic              exc_ov;

    logic              is_div;
    logic              is_sgn;
    logic [WIDTH-1:0]  mag_alo;
    logic [W2-1:0]     mag_a;
    logic [WIDTH-1:0]  mag_b;
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_t;
    logic [WIDTH:0]    div_sub;
    logic              div_ge;
    logic [WIDTH-1:0]  div_r;
    logic [W2-1:0]     prod;
    logic [W2-1:0]     prod_s;
    logic [WIDTH-1:0]  quo;
    logic [WIDTH-1:0]  rem;
    logic              range_ov;

    assign is_div  = op_r[1];
    assign is_sgn  = op_r[0];
    assign mag_alo = (is_sgn && a_r[WIDTH-1]) ? -a_r[WIDTH-1:0] : a_r[WIDTH-1:0];
    assign mag_a   = (is_sgn && a_r[W2-1])    ? -a_r            : a_r;
    assign mag_b   = (is_sgn && b_r[WIDTH-1]) ? -b_r            : b_r;

    // Multiply: {hi,lo} shifts right, multiplier bits leave lo as product bits enter.
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);

    // Divide: W+1-bit trial remainder; hi stays below the divisor so W bits hold it.
    assign div_t   = {hi, lo[WIDTH-1]};
    assign div_sub = div_t - {1'b0, opnd};
    assign div_ge  = div_t >= {1'b0, opnd};
    assign div_r   = WIDTH'(div_ge ? div_sub : div_t);

    assign prod     = {hi, lo};
    assign prod_s   = res_neg ? -prod : prod;
    assign quo      = res_neg ? -lo : lo;
    assign rem      = dvd_neg ? -hi : hi;
    assign range_ov = is_div && is_sgn && (res_neg ? (lo > MIN_MAG) : (lo > MAX_POS));

    assign ready_out = (state == IDLE);
    assign busy_out  = (state != IDLE);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= IDLE;
            op_r         <= '0;
            a_r          <= '0;
            b_r          <= '0;
            hi           <= '0;
            lo           <= '0;
            opnd         <= '0;
            cnt          <= '0;
            res_neg      <= 1'b0;
            dvd_neg      <= 1'b0;
            exc_dz       <= 1'b0;
            exc_ov       <= 1'b0;
            done_out     <= 1'b0;
            q_out        <= '0;
            ccr_out      <= '0;
            div_zero_out <= 1'b0;
        end else begin
            done_out <= 1'b0;
            if (abort_in) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_in) begin
                            op_r  <= op_in;
                            a_r   <= a_in;
                            b_r   <= b_in;
                            state <= PREP;
                        end
                    end
                    PREP: begin
                        res_neg <= is_sgn & ((is_div ? a_r[W2-1] : a_r[WIDTH-1]) ^ b_r[WIDTH-1]);
                        dvd_neg <= is_sgn & a_r[W2-1];
                        exc_dz  <= 1'b0;
                        exc_ov  <= 1'b0;
                        cnt     <= '0;
                        if (is_div) begin
                            hi   <= mag_a[W2-1:WIDTH];
                            lo   <= mag_a[WIDTH-1:0];
                            opnd <= mag_b;
                            if (mag_b == '0) begin
                                exc_dz <= 1'b1;
                                state  <= FIX;
                            end else if (mag_a[W2-1:WIDTH] >= mag_b) begin
                                exc_ov <= 1'b1;
                                state  <= FIX;
                            end else begin
                                state  <= ITER;
                            end
                        end else begin
                            hi    <= '0;
                            lo    <= mag_b;
                            opnd  <= mag_alo;
                            state <= ITER;
                        end
                    end
                    ITER: begin
                        if (is_div) begin
                            hi <= div_r;
                            lo <= {lo[WIDTH-2:0], div_ge};
                        end else begin
                            hi <= mul_sum[WIDTH:1];
                            lo <= {mul_sum[0], lo[WIDTH-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1))
                            state <= FIX;
                    end
                    FIX: begin
                        done_out <= 1'b1;
                        state    <= IDLE;
                        if (exc_dz) begin
                            q_out        <= a_r;
                            ccr_out      <= 4'b0010;
                            div_zero_out <= 1'b1;
                        end else if (exc_ov || range_ov) begin
                            q_out        <= a_r;
                            ccr_out      <= 4'b0010;
                            div_zero_out <= 1'b0;
                        end else if (is_div) begin
                            q_out        <= {rem, quo};
                            ccr_out      <= {quo[WIDTH-1], quo == '0, 1'b0, quo[0]};
                            div_zero_out <= 1'b0;
                        end else begin
                            q_out        <= prod_s;
                            ccr_out      <= {prod_s[W2-1], prod_s == '0, 1'b0, prod_s[WIDTH-1]};
                            div_zero_out <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
